// File: rtl/branch_outcome_tracker_if.sv
// Bundle between the IF/EX pipeline and the branch outcome tracker.
// The master side issues predictions and resolutions; the slave side (the tracker) drives updates and status.
interface branch_outcome_tracker_if #(
    parameter int ADDR_W = 3,
    parameter int CNT_W  = 16
);
    // Handshake: PRED_VALID / RES_VALID are single-cycle strobes sampled on the rising edge.
    // There is no back-pressure. IF must hold off PRED_VALID while FULL.
    // EX must raise RES_VALID only while a branch is in flight.
    // Violations are dropped and latch ERR.
    logic              PRED_VALID;
    logic [ADDR_W-1:0] PRED_ADDR;
    logic              PRED_TAKEN;
    logic              RES_VALID;
    logic              RES_TAKEN;
    logic              UPD_VALID;
    logic [ADDR_W-1:0] UPD_ADDR;
    logic              UPD_OUTCOME;
    logic              FLUSH;
    logic              FULL;
    logic              EMPTY;
    logic [CNT_W-1:0]  MISSES;
    logic [CNT_W-1:0]  BRANCHES;
    logic              ERR;

    modport master (
        output PRED_VALID, PRED_ADDR, PRED_TAKEN, RES_VALID, RES_TAKEN,
        input  UPD_VALID, UPD_ADDR, UPD_OUTCOME, FLUSH, FULL, EMPTY,
               MISSES, BRANCHES, ERR
    );

    modport slave (
        input  PRED_VALID, PRED_ADDR, PRED_TAKEN, RES_VALID, RES_TAKEN,
        output UPD_VALID, UPD_ADDR, UPD_OUTCOME, FLUSH, FULL, EMPTY,
               MISSES, BRANCHES, ERR
    );
endinterface

// File: rtl/branch_outcome_tracker.sv
// Holds in-flight branch predictions in program order and checks each one against the EX outcome.
// Drives predictor updates, a one-cycle flush on mispredict, and hit/miss statistics.
module branch_outcome_tracker #(
    parameter int ADDR_W = 3,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 16
) (
    input  logic                     CLOCK,
    input  logic                     RESET_N,
    branch_outcome_tracker_if.slave  bus,
    output logic [1:0]               state_dbg
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CW    = PTR_W + 1;
    localparam logic [CW-1:0]    FULL_CNT = CW'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_TRACK    = 2'd1,
        ST_FLUSHING = 2'd2
    } state_t;

    logic [ADDR_W-1:0] addr_mem [DEPTH];
    logic              pred_mem [DEPTH];

    state_t            state_q,       state_d;
    logic [PTR_W-1:0]  rd_ptr_q,      rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q,      wr_ptr_d;
    logic [CW-1:0]     count_q,       count_d;
    logic              upd_valid_q,   upd_valid_d;
    logic [ADDR_W-1:0] upd_addr_q,    upd_addr_d;
    logic              upd_outcome_q, upd_outcome_d;
    logic              flush_q,       flush_d;
    logic [CNT_W-1:0]  misses_q,      misses_d;
    logic [CNT_W-1:0]  branches_q,    branches_d;
    logic              err_q,         err_d;

    logic full, empty, flushing;
    logic res_ok, mispred, pop_ok, push_req, push_ok;

    always_comb begin
        full     = (count_q == FULL_CNT);
        empty    = (count_q == '0);
        flushing = (state_q == ST_FLUSHING);
        res_ok   = bus.RES_VALID && !empty && !flushing;
        mispred  = res_ok && (bus.RES_TAKEN != pred_mem[rd_ptr_q]);
        pop_ok   = res_ok && !mispred;
        push_req = bus.PRED_VALID && !flushing;
        // A correct pop frees a slot in the same cycle, so a full FIFO may still accept a push.
        push_ok  = push_req && !mispred && (!full || pop_ok);
    end

    always_comb begin
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        count_d       = count_q;
        upd_valid_d   = res_ok;
        upd_addr_d    = upd_addr_q;
        upd_outcome_d = upd_outcome_q;
        flush_d       = mispred;
        misses_d      = misses_q;
        branches_d    = branches_q;
        err_d         = err_q;
        state_d       = state_q;

        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end

        if (mispred) begin
            // Everything younger than the mispredicted branch is on the wrong path.
            rd_ptr_d = wr_ptr_q;
            count_d  = '0;
        end else begin
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CW'(push_ok) - CW'(pop_ok);
        end

        if (res_ok) begin
            upd_addr_d    = addr_mem[rd_ptr_q];
            upd_outcome_d = bus.RES_TAKEN;
            if (branches_q != CNT_MAX) begin
                branches_d = branches_q + CNT_W'(1);
            end
        end

        if (mispred && (misses_q != CNT_MAX)) begin
            misses_d = misses_q + CNT_W'(1);
        end

        if ((bus.RES_VALID && !res_ok) || (push_req && full && !res_ok)) begin
            err_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (push_ok) state_d = ST_TRACK;
            end
            ST_TRACK: begin
                if (mispred)              state_d = ST_FLUSHING;
                else if (count_d == '0)   state_d = ST_IDLE;
            end
            ST_FLUSHING: state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK) begin
        if (!RESET_N) begin
            state_q       <= ST_IDLE;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
            upd_valid_q   <= 1'b0;
            upd_addr_q    <= '0;
            upd_outcome_q <= 1'b0;
            flush_q       <= 1'b0;
            misses_q      <= '0;
            branches_q    <= '0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
            upd_valid_q   <= upd_valid_d;
            upd_addr_q    <= upd_addr_d;
            upd_outcome_q <= upd_outcome_d;
            flush_q       <= flush_d;
            misses_q      <= misses_d;
            branches_q    <= branches_d;
            err_q         <= err_d;
        end
    end

    // Entry storage needs no reset: the pointers alone decide which slots are live.
    always_ff @(posedge CLOCK) begin
        if (RESET_N && push_ok) begin
            addr_mem[wr_ptr_q] <= bus.PRED_ADDR;
            pred_mem[wr_ptr_q] <= bus.PRED_TAKEN;
        end
    end

    assign bus.UPD_VALID   = upd_valid_q;
    assign bus.UPD_ADDR    = upd_addr_q;
    assign bus.UPD_OUTCOME = upd_outcome_q;
    assign bus.FLUSH       = flush_q;
    assign bus.FULL        = full;
    assign bus.EMPTY       = empty;
    assign bus.MISSES      = misses_q;
    assign bus.BRANCHES    = branches_q;
    assign bus.ERR         = err_q;
    assign state_dbg       = state_q;

endmodule
